// File: rtl/sgbm_agg_pkg.sv
// Shared constants, widths and helpers for the SGBM cost-aggregation pipeline.
package sgbm_agg_pkg;

    localparam int DISP_RANGE    = 32'sd108;
    localparam int COST_W        = 32'sd8;
    localparam int MIN_DISPARITY = 32'sd0;
    localparam int MAX_DISPARITY = MIN_DISPARITY + DISP_RANGE - 32'sd1;
    localparam int P1            = 32'sd10;
    localparam int FRAME_WIDTH   = 32'sd400;
    localparam int FRAME_HEIGHT  = 32'sd300;
    localparam int COST_VEC_W    = DISP_RANGE * COST_W;

    // Operation performed by the line delay in a given cycle.
    typedef enum logic [1:0] {
        OP_IDLE   = 2'd0,
        OP_FILL   = 2'd1,
        OP_STEADY = 2'd2,
        OP_DRAIN  = 2'd3
    } delay_op_e;

    // Number of bits needed to index value distinct items.
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 32'sd0;
        rem  = value - 32'sd1;
        while (rem > 32'sd0) begin
            bits = bits + 32'sd1;
            rem  = rem >>> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port RAM: one write port, one read-first registered read port.
module delay_ram #(
    parameter int WIDTH  = 32'sd36,
    parameter int DEPTH  = 32'sd4,
    parameter int ADDR_W = 32'sd2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rd_data_r;

    // Storage array; contents survive reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds its value on cycles without a read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data_r <= {WIDTH{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/cost_line_delay.sv
// Delays a tagged cost vector by DEPTH accepted samples, with an end-of-frame drain.
module cost_line_delay
    import sgbm_agg_pkg::clog2;
    import sgbm_agg_pkg::delay_op_e;
#(
    parameter int  DISP_RANGE = sgbm_agg_pkg::DISP_RANGE,
    parameter int  COST_W     = sgbm_agg_pkg::COST_W,
    parameter int  DATA_W     = DISP_RANGE * COST_W,
    parameter int  ROW_W      = 32'sd10,
    parameter int  COL_W      = 32'sd10,
    parameter int  DEPTH      = sgbm_agg_pkg::FRAME_WIDTH,
    localparam int PTR_W      = clog2(DEPTH),
    localparam int CNT_W      = clog2(DEPTH + 32'sd1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              drain,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ROW_W-1:0]  row_in,
    input  logic [COL_W-1:0]  col_in,
    output logic              valid,
    output logic [DATA_W-1:0] data_out,
    output logic [ROW_W-1:0]  row_out,
    output logic [COL_W-1:0]  col_out,
    output logic [CNT_W-1:0]  count,
    output logic              drain_done
);

    localparam int               WORD_W   = DATA_W + ROW_W + COL_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 32'sd1);

    delay_op_e        op_s;
    logic [PTR_W-1:0] wr_ptr_r, wr_ptr_s;
    logic [PTR_W-1:0] rd_ptr_r, rd_ptr_s;
    logic [CNT_W-1:0] count_r, count_s;
    logic             valid_r, drain_done_r, drain_done_s;
    logic             wr_en_s, rd_en_s, ram_wr_en_s;
    logic [WORD_W-1:0] wr_word_s, rd_word_s;

    // Circular-pointer increment; explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == LAST_PTR) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    // Classify the cycle; a strobe always wins over a pending drain.
    always_comb begin
        op_s = sgbm_agg_pkg::OP_IDLE;
        if (en) begin
            if (count_r == FULL_CNT) begin
                op_s = sgbm_agg_pkg::OP_STEADY;
            end else begin
                op_s = sgbm_agg_pkg::OP_FILL;
            end
        end else if (drain && (count_r != {CNT_W{1'b0}})) begin
            op_s = sgbm_agg_pkg::OP_DRAIN;
        end else begin
            op_s = sgbm_agg_pkg::OP_IDLE;
        end
    end

    // Next pointer/occupancy values and RAM port enables for the chosen operation.
    always_comb begin
        wr_ptr_s     = wr_ptr_r;
        rd_ptr_s     = rd_ptr_r;
        count_s      = count_r;
        wr_en_s      = 1'b0;
        rd_en_s      = 1'b0;
        drain_done_s = 1'b0;
        case (op_s)
            sgbm_agg_pkg::OP_FILL: begin
                wr_en_s  = 1'b1;
                wr_ptr_s = ptr_inc(wr_ptr_r);
                count_s  = count_r + ONE_CNT;
            end
            sgbm_agg_pkg::OP_STEADY: begin
                wr_en_s  = 1'b1;
                rd_en_s  = 1'b1;
                wr_ptr_s = ptr_inc(wr_ptr_r);
                rd_ptr_s = ptr_inc(rd_ptr_r);
            end
            sgbm_agg_pkg::OP_DRAIN: begin
                rd_en_s      = 1'b1;
                rd_ptr_s     = ptr_inc(rd_ptr_r);
                count_s      = count_r - ONE_CNT;
                drain_done_s = (count_r == ONE_CNT);
            end
            default: begin
                wr_ptr_s = wr_ptr_r;
                rd_ptr_s = rd_ptr_r;
                count_s  = count_r;
            end
        endcase
    end

    // Control state and output strobes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            valid_r      <= 1'b0;
            drain_done_r <= 1'b0;
        end else begin
            wr_ptr_r     <= wr_ptr_s;
            rd_ptr_r     <= rd_ptr_s;
            count_r      <= count_s;
            valid_r      <= rd_en_s;
            drain_done_r <= drain_done_s;
        end
    end

    // Writes during reset are suppressed so a reset cycle never leaves a stale entry.
    assign ram_wr_en_s = wr_en_s & rst;
    assign wr_word_s   = {data_in, row_in, col_in};

    delay_ram #(
        .WIDTH  (WORD_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ram_wr_en_s),
        .wr_addr (wr_ptr_r),
        .wr_data (wr_word_s),
        .rd_en   (rd_en_s),
        .rd_addr (rd_ptr_r),
        .rd_data (rd_word_s)
    );

    // The RAM read register doubles as the output register, giving one-cycle latency.
    assign {data_out, row_out, col_out} = rd_word_s;
    assign valid      = valid_r;
    assign drain_done = drain_done_r;
    assign count      = count_r;

endmodule

// File: doc/cost_line_delay.md
Name: cost_line_delay

Overview:
- Parametrised successor to the single-stage cost delay buffer in the aggregate-cost pipeline.
- Delays a per-pixel disparity cost vector, with its row/col tags, by DEPTH accepted samples rather than by clock cycles. Typical use is a one-line delay for vertical-path aggregation.
- Adds a drain mode that flushes the remaining entries at frame end, an occupancy output, and a drain-done pulse.
- Sits between the cost computation stage and the path aggregators.

Parameters:
- DISP_RANGE, 108, number of disparities per cost vector.
- COST_W, 8, bits per disparity cost.
- DATA_W, DISP_RANGE*COST_W (864), cost vector width.
- ROW_W, 10, row tag width.
- COL_W, 10, column tag width.
- DEPTH, 400, delay in samples (frame_width for a line delay); must be at least 2.
- PTR_W, clog2(DEPTH), localparam, pointer width.
- CNT_W, clog2(DEPTH+1), localparam, occupancy counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-low.
- en  in  1  input sample strobe; data_in, row_in and col_in are valid this cycle.
- drain  in  1  flush request; level-sensitive; empties the buffer while en is low.
- data_in  in  DATA_W  cost vector.
- row_in  in  ROW_W  row tag.
- col_in  in  COL_W  column tag.
- valid  out  1  data_out, row_out and col_out are valid this cycle (one-cycle pulse per sample).
- data_out  out  DATA_W  delayed cost vector.
- row_out  out  ROW_W  delayed row tag.
- col_out  out  COL_W  delayed column tag.
- count  out  CNT_W  current occupancy, 0..DEPTH.
- drain_done  out  1  one-cycle pulse on the cycle count reaches 0 through drain.

Behaviour:
- Reset (rst==0 at a clk edge):
  - wr_ptr, rd_ptr and count go to 0.
  - valid, drain_done, data_out, row_out and col_out go to 0.
  - RAM contents are not cleared.
  - Reset mid-operation discards all held samples; no valid is emitted afterwards for them.
- Storage: circular buffer of DEPTH words of DATA_W+ROW_W+COL_W bits, holding {data, row, col}.
- Cycle with en=1 and count<DEPTH (fill phase):
  - write the input at wr_ptr; wr_ptr advances;
  - count increments;
  - no output.
- Cycle with en=1 and count==DEPTH (steady phase):
  - read rd_ptr and write wr_ptr (these are equal) in the same cycle, with read-before-write semantics;
  - both pointers advance;
  - count holds at DEPTH;
  - next cycle, valid=1 with the oldest sample. The output is therefore the sample accepted DEPTH en-strobes earlier.
- Cycle with en=0, drain=1 and count>0:
  - read rd_ptr; rd_ptr advances;
  - count decrements;
  - next cycle, valid=1.
  - When count goes from 1 to 0, drain_done=1 on the same cycle as that final valid.
- en=1 and drain=1 in the same cycle: en has priority; drain is ignored for that cycle.
- drain=1 with count==0: no action; no drain_done pulse.
- Pointer wrap: a pointer at DEPTH-1 returns to 0. Non-power-of-two DEPTH is required to work.
- Latency: exactly 1 cycle from the triggering edge to valid.
  - Outputs are registered; valid is low on any cycle with no read.
  - data_out, row_out and col_out hold their last value while valid=0.
- After a drain the buffer is empty. en resumes in the fill phase, and new frames are not mixed with old ones.
- No back-pressure input: the consumer must accept every valid. Overflow is impossible by construction.

Decomposition:
- Shared package sgbm_agg_pkg:
  - constants DISP_RANGE, COST_W, MIN_DISPARITY, MAX_DISPARITY, P1, FRAME_WIDTH, FRAME_HEIGHT;
  - a function for clog2;
  - the packed cost-vector width.
- Sub-module delay_ram:
  - simple dual-port RAM with one write port and one read port, read-first, 1-cycle registered read;
  - parametrised width and depth;
  - infers BRAM/URAM.
- cost_line_delay holds the pointers, counter, control and output registers.

Test Plan (bench with DEPTH=4, DISP_RANGE=2; data = sample index; row=0; col = index):
- Fill then steady: 8 consecutive en with samples 0..7 → no valid for samples 0..3. Valid on the cycle after en #4..#7 carries 0,1,2,3. count reads 1,2,3,4,4,4,4,4.
- Gapped input: en in every other cycle, samples 0..5 → outputs 0,1 with exactly 1-cycle latency after en #4 and en #5. Valid is never high on idle cycles.
- Drain: 6 samples in, then drain=1 for 6 cycles → valid carries 2,3,4,5 on consecutive cycles. drain_done coincides with sample 5. count ends at 0; the extra drain cycles produce nothing.
- Priority: count=4, en=1 and drain=1 together with sample 9 → a single valid carrying the oldest sample; count stays 4.
- Reset mid-frame: 3 samples in, rst=0 for one cycle, then 4 new samples 10..13 → no output during refill. The next en (sample 14) yields 10. Samples 0..2 never appear.
- Wrap stress: DEPTH=5 (non-power-of-two), 20 samples → outputs 0..14 in order with no gaps or duplicates.
